uart_rx: RTL and testbench

UART receiver, the counterpart of the existing UART transmitter. It takes the serial `rx` line (8N1, LSB first), samples it at OVERSAMPLE× the baud rate using an external one-cycle sample strobe, and presents each received byte in a holding register with a valid/ack handshake. It also flags framing and overrun errors. It sits inside the UART peripheral beside the transmitter and feeds the bus-readable data and status registers.

---
 rtl/uart_rx.sv | 176 +++++++++++++++++
 tb/tb_uart_rx.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, LSB first, oversampled by an external strobe.
// A received byte lands in a holding register with a valid/ack handshake;
// sticky framing and overrun flags are cleared by the same acknowledge.
module uart_rx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       rx,
  input  logic       sample_edge,
  input  logic       rd_ack,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_e;

  logic          rx_meta_q;
  logic          rx_s_q;
  state_e        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;
  logic          deliver;
  logic          stop_bad;

  // Two-flop synchronizer for the asynchronous serial line; idles high.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= IDLE;
      tick_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  // Frame sequencing, sampling at mid-bit, and the holding-register handshake.
  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = valid_q;
    ferr_d    = ferr_q;
    ovr_d     = ovr_q;
    deliver   = 1'b0;
    stop_bad  = 1'b0;

    case (state_q)
      IDLE: begin
        if (sample_edge && !rx_s_q) begin
          state_d = START;
          tick_d  = '0;
        end
      end
      START: begin
        if (sample_edge) begin
          if (tick_q == HALF_LAST) begin
            if (!rx_s_q) begin
              state_d   = DATA;
              tick_d    = '0;
              bit_idx_d = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      DATA: begin
        if (sample_edge) begin
          if (tick_q == FULL_LAST) begin
            shift_d   = {rx_s_q, shift_q[7:1]};
            tick_d    = '0;
            bit_idx_d = bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
              state_d = STOP;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      STOP: begin
        if (sample_edge) begin
          if (tick_q == FULL_LAST) begin
            tick_d = '0;
            if (rx_s_q) begin
              deliver = 1'b1;
              state_d = IDLE;
            end else begin
              stop_bad = 1'b1;
              state_d  = WAIT_IDLE;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      WAIT_IDLE: begin
        if (sample_edge && rx_s_q) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (rd_ack) begin
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      ovr_d   = 1'b0;
    end
    if (deliver) begin
      data_d  = shift_q;
      valid_d = 1'b1;
      if (valid_q && !rd_ack) begin
        ovr_d = 1'b1;
      end
    end
    if (stop_bad) begin
      ferr_d = 1'b1;
    end
  end

  assign data       = data_q;
  assign data_valid = valid_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized self-checking bench for uart_rx with a
// cycle-level reference model of delivery timing and flag behaviour.
module tb_uart_rx;

  localparam int OS     = 16;
  localparam int SE_DIV = 4;
  localparam int BIT_CY = OS * SE_DIV;

  logic       clk = 1'b0;
  logic       nrst;
  logic       rx;
  logic       sample_edge;
  logic       rd_ack;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int         cyc;
  int         checks;
  int         errors;
  bit         line[$];

  logic [7:0] m_data;
  bit         m_valid;
  bit         m_ferr;
  bit         m_ovr;

  uart_rx #(.OVERSAMPLE(OS)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .rx         (rx),
    .sample_edge(sample_edge),
    .rd_ack     (rd_ack),
    .data       (data),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Safety net so the run can never hang.
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one clock; drive the strobe, the line and a default deassert of rd_ack.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    sample_edge = (cyc % SE_DIV == 0);
    rd_ack      = 1'b0;
    if (line.size() > 0) rx = line.pop_front();
    else rx = 1'b1;
  endtask

  task automatic run_until(input int target);
    while (cyc < target) tick();
  endtask

  // Queue one frame on the line, one entry per clock.
  task automatic push_frame(input logic [7:0] b, input bit stop_ok, input int low_tail);
    repeat (BIT_CY) line.push_back(1'b0);
    for (int i = 0; i < 8; i++) repeat (BIT_CY) line.push_back(b[i]);
    repeat (BIT_CY) line.push_back(stop_ok);
    repeat (low_tail) line.push_back(1'b0);
  endtask

  // First strobe that sees the falling line through the 2-clock synchronizer.
  function automatic int first_edge(input int c_fall);
    int e;
    e = c_fall + 2;
    while (e % SE_DIV != 0) e++;
    return e;
  endfunction

  // Mid-stop-bit strobe: half a bit for the start, then nine full bits.
  function automatic int delivery_cycle(input int c_fall);
    return first_edge(c_fall) + SE_DIV * (OS / 2 + 9 * OS);
  endfunction

  // Send one frame, optionally acknowledge in the exact delivery cycle, and check.
  task automatic play_frame(input logic [7:0] b, input bit stop_ok, input int low_tail,
                            input bit ack_at_d, input string tag);
    int cf;
    int d;
    cf = cyc + line.size() + 1;
    push_frame(b, stop_ok, low_tail);
    d = delivery_cycle(cf);
    run_until(d);
    checks++;
    if (data_valid !== m_valid) begin
      errors++;
      $display("[TB] FAIL %s pre_valid: got %b expected %b", tag, data_valid, m_valid);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s pre_busy: got %b expected 1", tag, busy);
    end
    if (ack_at_d) rd_ack = 1'b1;
    tick();
    if (stop_ok) begin
      if (m_valid && !ack_at_d) m_ovr = 1'b1;
      else if (ack_at_d) m_ovr = 1'b0;
      if (ack_at_d) m_ferr = 1'b0;
      m_data  = b;
      m_valid = 1'b1;
    end else begin
      if (ack_at_d) begin
        m_valid = 1'b0;
        m_ovr   = 1'b0;
      end
      m_ferr = 1'b1;
    end
    checks++;
    if (data !== m_data) begin
      errors++;
      $display("[TB] FAIL %s data: got %h expected %h", tag, data, m_data);
    end
    checks++;
    if (data_valid !== m_valid) begin
      errors++;
      $display("[TB] FAIL %s valid: got %b expected %b", tag, data_valid, m_valid);
    end
    checks++;
    if (frame_err !== m_ferr) begin
      errors++;
      $display("[TB] FAIL %s frame_err: got %b expected %b", tag, frame_err, m_ferr);
    end
    checks++;
    if (overrun !== m_ovr) begin
      errors++;
      $display("[TB] FAIL %s overrun: got %b expected %b", tag, overrun, m_ovr);
    end
    checks++;
    if (busy !== !stop_ok) begin
      errors++;
      $display("[TB] FAIL %s post_busy: got %b expected %b", tag, busy, !stop_ok);
    end
  endtask

  // Single-cycle acknowledge away from any delivery.
  task automatic do_ack(input string tag);
    rd_ack = 1'b1;
    tick();
    m_valid = 1'b0;
    m_ferr  = 1'b0;
    m_ovr   = 1'b0;
    checks++;
    if (data_valid !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s ack_flags: got %b%b%b expected 000", tag,
               data_valid, frame_err, overrun);
    end
    checks++;
    if (data !== m_data) begin
      errors++;
      $display("[TB] FAIL %s ack_data: got %h expected %h", tag, data, m_data);
    end
  endtask

  task automatic test_reset();
    nrst        = 1'b0;
    rx          = 1'b1;
    sample_edge = 1'b0;
    rd_ack      = 1'b0;
    cyc         = 0;
    m_data      = 8'h00;
    m_valid     = 1'b0;
    m_ferr      = 1'b0;
    m_ovr       = 1'b0;
    #1;
    checks++;
    if ({data, data_valid, frame_err, overrun, busy} !== 12'h000) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h/%b%b%b%b expected 00/0000", data,
               data_valid, frame_err, overrun, busy);
    end
    repeat (4) tick();
    nrst = 1'b1;
    repeat (20) tick();
  endtask

  task automatic test_good_frame();
    play_frame(8'h55, 1'b1, 0, 1'b0, "good55");
  endtask

  task automatic test_glitch();
    int cf;
    int e0;
    do_ack("glitch_pre");
    repeat (BIT_CY) tick();
    cf = cyc + line.size() + 1;
    repeat (5 * SE_DIV) line.push_back(1'b0);
    e0 = first_edge(cf);
    run_until(e0 + 1);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL glitch_busy_on: got %b expected 1", busy);
    end
    run_until(e0 + SE_DIV * (OS / 2) + 1);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL glitch_busy_off: got %b expected 0", busy);
    end
    checks++;
    if (data_valid !== m_valid || frame_err !== m_ferr) begin
      errors++;
      $display("[TB] FAIL glitch_flags: got %b%b expected %b%b", data_valid, frame_err,
               m_valid, m_ferr);
    end
  endtask

  task automatic test_break();
    int cf;
    int r;
    int e;
    repeat (BIT_CY) tick();
    cf = cyc + line.size() + 1;
    play_frame(8'hA3, 1'b0, 2 * BIT_CY, 1'b0, "breakA3");
    r = cf + 10 * BIT_CY + 2 * BIT_CY;
    run_until(r);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL break_busy_hold: got %b expected 1", busy);
    end
    e = first_edge(r);
    run_until(e + 1);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL break_busy_release: got %b expected 0", busy);
    end
    play_frame(8'h3C, 1'b1, 0, 1'b0, "after_break3C");
  endtask

  task automatic test_back_to_back();
    play_frame(8'h12, 1'b1, 0, 1'b0, "b2b12");
    play_frame(8'h34, 1'b1, 0, 1'b0, "b2b34");
    do_ack("b2b_ack");
  endtask

  task automatic test_reset_mid_frame();
    int cf;
    cf = cyc + line.size() + 1;
    push_frame(8'hFF, 1'b1, 0);
    run_until(cf + 5 * BIT_CY);
    nrst = 1'b0;
    #1;
    checks++;
    if ({data, data_valid, frame_err, overrun, busy} !== 12'h000) begin
      errors++;
      $display("[TB] FAIL midreset_outputs: got %h/%b%b%b%b expected 00/0000", data,
               data_valid, frame_err, overrun, busy);
    end
    line.delete();
    repeat (3) tick();
    nrst    = 1'b1;
    m_data  = 8'h00;
    m_valid = 1'b0;
    m_ferr  = 1'b0;
    m_ovr   = 1'b0;
    repeat (20) tick();
    play_frame(8'hC7, 1'b1, 0, 1'b0, "after_resetC7");
  endtask

  task automatic test_ack_collision();
    do_ack("collide_pre");
    play_frame(8'h7E, 1'b1, 0, 1'b0, "collide7E");
    play_frame(8'h81, 1'b1, 0, 1'b1, "collide81");
  endtask

  task automatic test_random();
    bit prev_bad;
    prev_bad = 1'b0;
    for (int n = 0; n < 10; n++) begin
      logic [7:0] b;
      bit         good;
      bit         ack;
      int         gap;
      b    = 8'($urandom);
      good = ($urandom_range(0, 4) != 0);
      ack  = ($urandom_range(0, 3) == 0);
      gap  = $urandom_range(0, 40);
      if (prev_bad) gap = gap + 24;
      repeat (gap) line.push_back(1'b1);
      play_frame(b, good, 0, ack, "random");
      prev_bad = !good;
      if ($urandom_range(0, 2) == 0) do_ack("random_ack");
    end
  endtask

  // Scenario sequence and summary.
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_good_frame();
    test_glitch();
    test_break();
    test_back_to_back();
    test_reset_mid_frame();
    test_ack_collision();
    test_random();
    repeat (BIT_CY) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
